// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the RV32 5-stage pipeline hazard logic.
// Contents: forwarding-select encodings and the register address width.
package hazard_unit_pkg;

    localparam int REG_ADDR_W = 5;

    // Operand forwarding select encodings (11 is never produced)
    localparam logic [1:0] FWD_RF  = 2'b00;   // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;   // W-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;   // M-stage ALU result

    // Architectural zero register; never a forwarding or hazard source
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Forwarding source selection for one E-stage ALU operand.
// Ports:
//   rs_e       - E-stage source register of this operand
//   rd_m, rd_w - destination registers in M and W
//   regwrite_m, regwrite_w - M/W instructions write the register file
//   sel        - FWD_MEM if M matches, else FWD_WB if W matches, else FWD_RF
module forward_sel
    import hazard_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    output logic [1:0]            sel
);

    logic [1:0] sel_s;

    // Prioritised match: the younger M-stage result wins over W; x0 never forwards
    always_comb begin
        sel_s = FWD_RF;
        if (regwrite_m && (rd_m != REG_X0) && (rd_m == rs_e)) begin
            sel_s = FWD_MEM;
        end else if (regwrite_w && (rd_w != REG_X0) && (rd_w == rs_e)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage RV32 pipeline.
// Control outputs are combinational; only the event counters are registered.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   pcsrc_e                - taken branch / jump resolved in E
//   rs1_d, rs2_d           - D-stage source registers
//   rd_e, resultsrc_e0     - E-stage destination and "is a load" flag
//   rs1_e, rs2_e           - E-stage source registers
//   rd_m, rd_w, regwrite_m, regwrite_w - M/W writeback info
//   forward_ae, forward_be - operand A/B forwarding selects
//   stall_f, stall_d       - hold PC and F/D register
//   flush_d, flush_e       - clear F/D and D/E registers
//   stall_cnt, flush_cnt   - saturating load-use stall / branch flush counters
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pcsrc_e,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  resultsrc_e0,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  regwrite_m,
    input  logic                  regwrite_w,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;
    logic             lw_stall_s;
    logic [1:0]       forward_ae_s;
    logic [1:0]       forward_be_s;
    logic             stall_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    forward_sel u_fwd_a (
        .rs_e       (rs1_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .sel        (fwd_a_s)
    );

    forward_sel u_fwd_b (
        .rs_e       (rs2_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .sel        (fwd_b_s)
    );

    // Load-use hazard: a load in E feeds a D-stage source; loads to x0 are harmless
    always_comb begin
        lw_stall_s = 1'b0;
        if (resultsrc_e0 && (rd_e != REG_X0) && ((rs1_d == rd_e) || (rs2_d == rd_e))) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
    end

    // Control outputs; reset forces bubbles into D and E so the pipeline drains
    always_comb begin
        forward_ae_s = FWD_RF;
        forward_be_s = FWD_RF;
        stall_s      = 1'b0;
        flush_d_s    = 1'b1;
        flush_e_s    = 1'b1;
        if (rst) begin
            forward_ae_s = FWD_RF;
            forward_be_s = FWD_RF;
            stall_s      = 1'b0;
            flush_d_s    = 1'b1;
            flush_e_s    = 1'b1;
        end else begin
            forward_ae_s = fwd_a_s;
            forward_be_s = fwd_b_s;
            stall_s      = lw_stall_s;
            flush_d_s    = pcsrc_e;
            flush_e_s    = lw_stall_s | pcsrc_e;
        end
    end

    // Saturating performance counters for stall and flush events
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (lw_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (pcsrc_e && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign forward_ae = forward_ae_s;
    assign forward_be = forward_be_s;
    assign stall_f    = stall_s;
    assign stall_d    = stall_s;
    assign flush_d    = flush_d_s;
    assign flush_e    = flush_e_s;
    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs. The driver pushes expected responses computed from
// the hazard rules; a monitor on the falling edge pops and compares.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcsrc_e;
    logic [4:0] rs1_d, rs2_d, rd_e, rs1_e, rs2_e, rd_m, rd_w;
    logic       resultsrc_e0, regwrite_m, regwrite_w;

    logic [1:0]  forward_ae, forward_be;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [15:0] stall_cnt, flush_cnt;

    logic [1:0] s_forward_ae, s_forward_be;
    logic       s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int tests_run = 0;
    int failed    = 0;

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
        int         sc, fc, sc2, fc2;
    } exp_t;

    exp_t sb_q[$];

    // Unbounded event counts since last reset; saturation applied when predicting
    int stall_events = 0;
    int flush_events = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pcsrc_e(pcsrc_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_e(rd_e), .resultsrc_e0(resultsrc_e0), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .forward_ae(forward_ae), .forward_be(forward_be), .stall_f(stall_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .pcsrc_e(pcsrc_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_e(rd_e), .resultsrc_e0(resultsrc_e0), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .forward_ae(s_forward_ae), .forward_be(s_forward_be), .stall_f(s_stall_f),
        .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and predict the response seen before the next edge
    task automatic drive(input logic r, input logic pc, input logic ld,
                         input logic [4:0] a1d, input logic [4:0] a2d, input logic [4:0] rde,
                         input logic [4:0] a1e, input logic [4:0] a2e,
                         input logic [4:0] rdm, input logic [4:0] rdw,
                         input logic wm, input logic ww);
        exp_t e;
        logic lw;
        @(posedge clk);
        #2;
        rst = r; pcsrc_e = pc; resultsrc_e0 = ld;
        rs1_d = a1d; rs2_d = a2d; rd_e = rde; rs1_e = a1e; rs2_e = a2e;
        rd_m = rdm; rd_w = rdw; regwrite_m = wm; regwrite_w = ww;
        lw = ld && (rde != 5'd0) && (a1d == rde || a2d == rde);
        if (r) begin
            e.fa = 2'b00; e.fb = 2'b00;
            e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b1; e.fe = 1'b1;
        end else begin
            e.fa = ref_fwd(a1e, rdm, rdw, wm, ww);
            e.fb = ref_fwd(a2e, rdm, rdw, wm, ww);
            e.sf = lw; e.sd = lw; e.fd = pc; e.fe = lw | pc;
        end
        e.sc  = sat(stall_events, 16);
        e.fc  = sat(flush_events, 16);
        e.sc2 = sat(stall_events, 2);
        e.fc2 = sat(flush_events, 2);
        sb_q.push_back(e);
        if (r) begin
            stall_events = 0;
            flush_events = 0;
        end else begin
            stall_events += lw ? 1 : 0;
            flush_events += pc ? 1 : 0;
        end
    endtask

    // Monitor: compare every presented cycle against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("forward_ae", 32'(forward_ae), 32'(e.fa));
            check("forward_be", 32'(forward_be), 32'(e.fb));
            check("stall_f",    32'(stall_f),    32'(e.sf));
            check("stall_d",    32'(stall_d),    32'(e.sd));
            check("flush_d",    32'(flush_d),    32'(e.fd));
            check("flush_e",    32'(flush_e),    32'(e.fe));
            check("stall_cnt",  32'(stall_cnt),  32'(e.sc));
            check("flush_cnt",  32'(flush_cnt),  32'(e.fc));
            check("sat_stall_cnt", 32'(s_stall_cnt), 32'(e.sc2));
            check("sat_flush_cnt", 32'(s_flush_cnt), 32'(e.fc2));
        end
    end

    initial begin
        int wait_cycles;
        logic [4:0] v[9];
        rst = 1'b1; pcsrc_e = 1'b0; resultsrc_e0 = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0;
        // Initial reset without scoreboard entries: counters are unknown before it
        repeat (2) @(posedge clk);

        //     rst   pc    ld    rs1d   rs2d   rde    rs1e   rs2e   rdm    rdw    wm    ww
        drive(1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0); // reset
        drive(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0); // idle
        drive(1'b0, 1'b1, 1'b1, 5'd1,  5'd8,  5'd4,  5'd4,  5'd1,  5'd1,  5'd4,  1'b1, 1'b1); // branch+fwd
        drive(1'b0, 1'b0, 1'b0, 5'd16, 5'd1,  5'd4,  5'd2,  5'd8,  5'd1,  5'd16, 1'b1, 1'b1); // no match
        drive(1'b0, 1'b1, 1'b1, 5'd2,  5'd4,  5'd8,  5'd0,  5'd2,  5'd8,  5'd1,  1'b0, 1'b0); // regwrite off
        drive(1'b0, 1'b0, 1'b1, 5'd0,  5'd5,  5'd5,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0); // load-use
        drive(1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0); // rd_e = 0
        drive(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd3,  5'd0,  5'd3,  5'd3,  1'b1, 1'b1); // M over W
        drive(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1); // x0 never fwd
        drive(1'b0, 1'b1, 1'b1, 5'd7,  5'd0,  5'd7,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0); // stall+flush
        drive(1'b1, 1'b1, 1'b1, 5'd7,  5'd7,  5'd7,  5'd3,  5'd3,  5'd3,  5'd3,  1'b1, 1'b1); // mid reset
        drive(1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0);
        // Hold a load-use stall and a branch for five cycles to hit 2-bit saturation
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Randomized traffic with a narrow register range so matches are frequent
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 7; k++) begin
                if ($urandom_range(0, 7) == 0) v[k] = 5'($urandom_range(0, 31));
                else v[k] = 5'($urandom_range(0, 3));
            end
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  v[0], v[1], v[2], v[3], v[4], v[5], v[6],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard detection and forwarding control for the 5-stage in-order RV32 pipeline (F/D/E/M/W).
- Combinationally selects the E-stage ALU operand forwarding sources.
- Detects load-use hazards and stalls F/D while bubbling E.
- Flushes D/E on a taken branch or jump resolved in E.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt event counters

Ports:
clk  in  1  pipeline clock; counters update on the rising edge
rst  in  1  synchronous active-high reset
pcsrc_e  in  1  branch taken or jump in E stage
rs1_d  in  5  source register 1 of D-stage instruction
rs2_d  in  5  source register 2 of D-stage instruction
rd_e  in  5  destination register of E-stage instruction
resultsrc_e0  in  1  bit 0 of E-stage result select; 1 = E instruction is a load
rs1_e  in  5  source register 1 of E-stage instruction
rs2_e  in  5  source register 2 of E-stage instruction
rd_m  in  5  destination register in M stage
rd_w  in  5  destination register in W stage
regwrite_m  in  1  M-stage instruction writes the register file
regwrite_w  in  1  W-stage instruction writes the register file
forward_ae  out  2  operand A select: 00 = regfile, 01 = W result, 10 = M ALU result
forward_be  out  2  operand B select, same encoding as forward_ae
stall_f  out  1  hold the PC register
stall_d  out  1  hold the F/D pipeline register
flush_d  out  1  clear the F/D pipeline register
flush_e  out  1  clear the D/E pipeline register (insert bubble)
stall_cnt  out  CNT_W  number of load-use stall cycles since reset
flush_cnt  out  CNT_W  number of branch-flush cycles since reset

Behaviour:
- Control outputs are purely combinational with zero latency. Only the counters are registered.
- forward_ae:
  - 10 if regwrite_m && rd_m != 0 && rd_m == rs1_e.
  - Else 01 if regwrite_w && rd_w != 0 && rd_w == rs1_e.
  - Else 00.
  - M has priority over W when both match. Encoding 11 is never produced.
- forward_be: identical rule using rs2_e.
- Register x0 never forwards, even with regwrite asserted.
- lw_stall = resultsrc_e0 && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e).
- stall_f = stall_d = lw_stall.
- flush_d = pcsrc_e.
- flush_e = lw_stall | pcsrc_e.
- Simultaneous lw_stall and pcsrc_e: all four of stall_f, stall_d, flush_d, flush_e are 1.
- While rst = 1:
  - forward_ae = forward_be = 00.
  - stall_f = stall_d = 0.
  - flush_d = flush_e = 1, so the pipeline drains to bubbles.
  - Both counters clear to 0 on the clock edge.
- Counters, evaluated only when rst = 0:
  - stall_cnt increments by 1 on each rising edge where lw_stall = 1.
  - flush_cnt increments by 1 on each rising edge where pcsrc_e = 1.
  - Both saturate at 2^CNT_W - 1 and do not wrap.
  - Both may increment in the same cycle.
- Reset asserted mid-operation: control outputs take their reset values immediately; counters clear at the next edge.

Decomposition:
- Shared pipeline package holds:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_ADDR_W = 5.
- One sub-module, forward_sel, instantiated twice (operand A and B).
  - Inputs: rs_e, rd_m, rd_w, regwrite_m, regwrite_w.
  - Output: 2-bit select.
- Stall/flush logic and the counters stay in hazard_unit.

Test Plan:
- Idle: all inputs 0, rst = 0 -> forward_ae = forward_be = 00; stall_f, stall_d, flush_d, flush_e all 0; counters unchanged.
- Branch with forwarding:
  - Stimulus: pcsrc_e = 1, resultsrc_e0 = 1, rd_e = 4, rs1_d = 1, rs2_d = 8, rs1_e = 4, rs2_e = 1, rd_m = 1, rd_w = 4, regwrite_m = regwrite_w = 1.
  - Required: forward_ae = 01, forward_be = 10, stalls 0, flush_d = flush_e = 1, flush_cnt increments by 1.
- No match:
  - Stimulus: pcsrc_e = 0, resultsrc_e0 = 0, rs1_e = 2, rs2_e = 8, rd_m = 1, rd_w = 16, regwrites 1, rs1_d = 16, rs2_d = 1, rd_e = 4.
  - Required: all control outputs 0.
- Regwrite disabled:
  - Stimulus: pcsrc_e = 1, rs1_e = 0, rs2_e = 2, rd_m = 8, rd_w = 1, regwrites 0, resultsrc_e0 = 1, rd_e = 8, rs1_d = 2, rs2_d = 4.
  - Required: forward 00/00, no stall, flush_d = flush_e = 1.
- Load-use and priority:
  - Load-use: resultsrc_e0 = 1, rd_e = 5, rs2_d = 5 -> stall_f = stall_d = flush_e = 1, flush_d = 0, stall_cnt increments.
  - Same with rd_e = 0 -> no stall.
  - M/W priority: rs1_e = rd_m = rd_w = 3, both regwrites 1 -> forward_ae = 10.
- Reset and saturation:
  - rst = 1 -> flush_d = flush_e = 1, stalls 0, forwards 00, counters 0 after the edge.
  - With CNT_W = 2, hold lw_stall for 5 cycles -> stall_cnt stops at 3.
